mem_port_arbiter: RTL and testbench

//  Shares the single-port unified memory between the instruction-fetch requester (FSM fetch state)
//  and the data requester (LDR/STR/SWP states). Fixed data-over-fetch priority with a fetch

---
 rtl/cson_mem_pkg.sv | 20 ++
 rtl/mem_lat_timer.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cson_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cson_mem_pkg
//  Description : Shared state and owner encodings for the memory port arbiter.
//  Revision    : 1.0
// ============================================================================
package cson_mem_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // MEM_LAT is bounded to 15, so four bits always hold the latency count.
    localparam int LAT_CW = 4;

endpackage
`default_nettype wire

// File: rtl/mem_lat_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lat_timer
//  Description : Loads MEM_LAT on a read grant and counts down to zero.
//  Revision    : 1.0
// ============================================================================
module mem_lat_timer
    import cson_mem_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic last_o,
    output logic done_o
);

    logic [LAT_CW-1:0] cnt_q;
    logic [LAT_CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LAT_CW'(MEM_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == LAT_CW'(1));
    assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Single-port memory arbiter, data-over-fetch with starvation guard and SWP lock.
//  Revision    : 1.0
// ============================================================================
module mem_port_arbiter
    import cson_mem_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_lock,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          lock_q, lock_d;
    logic [SW-1:0] starve_cnt_q;
    logic          if_rvalid_q, d_rvalid_q;
    logic [DW-1:0] if_rdata_q, d_rdata_q;

    logic w_arb_en, w_fetch_pri, w_d_win, w_if_win;
    logic w_lat_last, w_lat_done, w_capture;

    // Grants are masked while reset is asserted so the memory port is quiet at once.
    assign w_arb_en    = rst_n && ((state_q == IDLE) || (state_q == LOCKED));
    assign w_fetch_pri = (starve_cnt_q == STARVE_LIM);
    assign w_d_win     = w_arb_en && d_req &&
                         ((state_q == LOCKED) || !(w_fetch_pri && if_req));
    assign w_if_win    = w_arb_en && (state_q == IDLE) && if_req && !w_d_win;
    assign w_capture   = (state_q == RD_WAIT) && w_lat_last;

    mem_lat_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (mem_en && !mem_we),
        .last_o (w_lat_last),
        .done_o (w_lat_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE, LOCKED: begin
                if (w_d_win) begin
                    owner_d = OWN_D;
                    lock_d  = d_lock && !d_we;
                    state_d = d_we ? IDLE : RD_WAIT;
                end else if (w_if_win) begin
                    owner_d = OWN_IF;
                    lock_d  = 1'b0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (w_lat_done) begin
                    state_d = ((owner_q == OWN_D) && lock_q) ? LOCKED : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_gnt    = w_if_win;
        d_gnt     = w_d_win;
        mem_en    = w_if_win || w_d_win;
        mem_we    = w_d_win && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_d_win) begin
            mem_addr  = d_addr;
            mem_wdata = d_we ? d_wdata : '0;
        end else if (w_if_win) begin
            mem_addr  = if_addr;
        end
        busy = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OWN_IF;
            lock_q       <= 1'b0;
            starve_cnt_q <= '0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            owner_q     <= owner_d;
            lock_q      <= lock_d;
            if_rvalid_q <= w_capture && (owner_q == OWN_IF);
            d_rvalid_q  <= w_capture && (owner_q == OWN_D);
            if (w_capture && (owner_q == OWN_IF)) begin
                if_rdata_q <= mem_rdata;
            end
            if (w_capture && (owner_q == OWN_D)) begin
                d_rdata_q <= mem_rdata;
            end
            // Only arbitration cycles in IDLE count towards fetch starvation.
            if (!if_req || w_if_win) begin
                starve_cnt_q <= '0;
            end else if ((state_q == IDLE) && !w_fetch_pri) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed bench; one arbiter with MEM_LAT=1 and one with MEM_LAT=3.
//  Revision    : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, d_lock;
    logic [31:0] if_addr, d_addr, d_wdata;

    logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1, busy1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, busy3;
    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3),
        .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
    );

    // Memory model: writes come only from dut1; reads return data exactly MEM_LAT
    // cycles after the strobe and a marker value at every other time.
    bit [31:0]   mem [256];
    bit          written [256];
    logic [31:0] rd1_q;
    logic [31:0] rd3_q [3];

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        if (written[a]) return mem[a];
        case (a)
            8'h10:   return 32'hE3A0_0001;
            8'h14:   return 32'hA5A5_0014;
            8'h40:   return 32'h1234_5678;
            default: return {24'h00C0DE, a};
        endcase
    endfunction

    always @(posedge clk) begin
        rd1_q    <= (mem_en1 && !mem_we1) ? mem_word(mem_addr1[7:0]) : 32'hBAD0_0001;
        rd3_q[0] <= (mem_en3 && !mem_we3) ? mem_word(mem_addr3[7:0]) : 32'hBAD0_0003;
        rd3_q[1] <= rd3_q[0];
        rd3_q[2] <= rd3_q[1];
        if (mem_en1 && mem_we1) begin
            mem[mem_addr1[7:0]]     <= mem_wdata1;
            written[mem_addr1[7:0]] <= 1'b1;
        end
    end

    assign mem_rdata1 = rd1_q;
    assign mem_rdata3 = rd3_q[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks follow 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_lock = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        step(); step();
        #1;
        chk("rst_busy",      {31'd0, busy1},      32'd0);
        chk("rst_mem_en",    {31'd0, mem_en1},    32'd0);
        chk("rst_if_rdata",  if_rdata1,           32'd0);
        chk("rst_d_rdata",   d_rdata1,            32'd0);
        chk("rst_if_rvalid", {31'd0, if_rvalid1}, 32'd0);
        step(); rst_n = 1'b1;

        // 1: fetch read, MEM_LAT=1
        step(); if_req = 1'b1; if_addr = 32'h10; #1;
        chk("t1_if_gnt",   {31'd0, if_gnt1}, 32'd1);
        chk("t1_mem_addr", mem_addr1,        32'h10);
        chk("t1_mem_we",   {31'd0, mem_we1}, 32'd0);
        step(); idle_inputs(); #1;
        chk("t1_rvalid_t1", {31'd0, if_rvalid1}, 32'd0);
        chk("t1_busy",      {31'd0, busy1},      32'd1);
        step(); #1;
        chk("t1_rvalid_t2", {31'd0, if_rvalid1}, 32'd1);
        chk("t1_if_rdata",  if_rdata1,           32'hE3A0_0001);
        step(); #1;
        chk("t1_rvalid_t3", {31'd0, if_rvalid1}, 32'd0);
        chk("t1_rdata_hold", if_rdata1,          32'hE3A0_0001);
        repeat (4) step();

        // 2: simultaneous requests, data write wins
        step(); if_req = 1'b1; if_addr = 32'h14;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55; #1;
        chk("t2_d_gnt",     {31'd0, d_gnt1},  32'd1);
        chk("t2_if_gnt",    {31'd0, if_gnt1}, 32'd0);
        chk("t2_mem_we",    {31'd0, mem_we1}, 32'd1);
        chk("t2_mem_addr",  mem_addr1,        32'h20);
        chk("t2_mem_wdata", mem_wdata1,       32'h55);
        step(); d_req = 1'b0; d_we = 1'b0; #1;
        chk("t2_if_gnt_next", {31'd0, if_gnt1}, 32'd1);
        chk("t2_mem_addr2",   mem_addr1,        32'h14);
        step(); idle_inputs();
        step(); #1;
        chk("t2_if_rvalid", {31'd0, if_rvalid1}, 32'd1);
        chk("t2_if_rdata",  if_rdata1,           32'hA5A5_0014);
        step(); d_req = 1'b1; d_addr = 32'h20; #1;
        chk("t2_rd_gnt", {31'd0, d_gnt1}, 32'd1);
        step(); idle_inputs();
        step(); #1;
        chk("t2_d_rvalid", {31'd0, d_rvalid1}, 32'd1);
        chk("t2_d_rdata",  d_rdata1,           32'h55);
        repeat (4) step();

        // 3: fetch starvation override after four lost arbitrations
        for (int i = 1; i <= 4; i++) begin
            step(); if_req = 1'b1; if_addr = 32'h18;
            d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'(i); #1;
            chk($sformatf("t3_d_gnt_%0d", i),  {31'd0, d_gnt1},  32'd1);
            chk($sformatf("t3_if_gnt_%0d", i), {31'd0, if_gnt1}, 32'd0);
        end
        step(); #1;
        chk("t3_if_gnt_5", {31'd0, if_gnt1}, 32'd1);
        chk("t3_d_gnt_5",  {31'd0, d_gnt1},  32'd0);
        step(); idle_inputs();
        step(); #1;
        chk("t3_if_rdata", if_rdata1, 32'h00C0_DE18);
        repeat (4) step();

        // 4: SWP lock keeps fetch out until the write completes
        step(); if_req = 1'b1; if_addr = 32'h1C;
        d_req = 1'b1; d_we = 1'b0; d_lock = 1'b1; d_addr = 32'h40; #1;
        chk("t4_rd_gnt", {31'd0, d_gnt1}, 32'd1);
        chk("t4_if_gnt", {31'd0, if_gnt1}, 32'd0);
        step(); d_req = 1'b0; d_lock = 1'b0; #1;
        chk("t4_if_gnt_w1", {31'd0, if_gnt1}, 32'd0);
        step(); #1;
        chk("t4_d_rvalid", {31'd0, d_rvalid1}, 32'd1);
        chk("t4_d_rdata",  d_rdata1,           32'h1234_5678);
        chk("t4_if_gnt_w2", {31'd0, if_gnt1},  32'd0);
        step(); #1;
        chk("t4_if_gnt_locked", {31'd0, if_gnt1}, 32'd0);
        chk("t4_busy_locked",   {31'd0, busy1},   32'd1);
        step(); d_req = 1'b1; d_we = 1'b1; d_wdata = 32'h8765_4321; #1;
        chk("t4_wr_gnt", {31'd0, d_gnt1},  32'd1);
        chk("t4_wr_we",  {31'd0, mem_we1}, 32'd1);
        chk("t4_if_gnt_wr", {31'd0, if_gnt1}, 32'd0);
        step(); d_req = 1'b0; d_we = 1'b0; #1;
        chk("t4_if_gnt_after", {31'd0, if_gnt1}, 32'd1);
        step(); idle_inputs();
        step(); #1;
        chk("t4_if_rdata", if_rdata1, 32'h00C0_DE1C);

        // 5: MEM_LAT=3 data read on dut3
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;
        step(); d_req = 1'b1; d_addr = 32'h40; #1;
        chk("t5_d_gnt", {31'd0, d_gnt3}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step(); idle_inputs(); #1;
            chk($sformatf("t5_busy_%0d", i),   {31'd0, busy3},     32'd1);
            chk($sformatf("t5_rvalid_%0d", i), {31'd0, d_rvalid3}, 32'd0);
        end
        step(); #1;
        chk("t5_rvalid_4", {31'd0, d_rvalid3}, 32'd1);
        chk("t5_d_rdata",  d_rdata3,           32'h8765_4321);
        chk("t5_busy_4",   {31'd0, busy3},     32'd1);
        step(); #1;
        chk("t5_busy_5",   {31'd0, busy3},     32'd0);
        chk("t5_rvalid_5", {31'd0, d_rvalid3}, 32'd0);

        // 6: asynchronous reset in RD_WAIT aborts the access
        step(); if_req = 1'b1; if_addr = 32'h10; #1;
        chk("t6_if_gnt", {31'd0, if_gnt1}, 32'd1);
        step(); if_req = 1'b0; #2;
        rst_n = 1'b0; d_req = 1'b1; d_addr = 32'h40; #1;
        chk("t6_busy",   {31'd0, busy1},  32'd0);
        chk("t6_mem_en", {31'd0, mem_en1}, 32'd0);
        chk("t6_d_gnt",  {31'd0, d_gnt1}, 32'd0);
        step(); idle_inputs();
        step(); rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step(); #1;
            chk($sformatf("t6_no_rvalid_%0d", i), {31'd0, if_rvalid1}, 32'd0);
        end
        chk("t6_if_rdata", if_rdata1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
